gate_truth_sequencer: RTL and testbench
=======================================

// Module: gate_truth_sequencer
// PURPOSE
//  Self-checking controller for any 2-input logic gate (NOR by default).
//  Steps the gate's inputs through all four combinations {a,b} = 00,01,10,11.
//  Waits a settle window for each, samples the gate output and compares it with a truth table.
//  Sits beside the gate instance and drives its a/b pins; pass/fail goes to a top-level status.
// PARAMETERS
//  TRUTH       4'b0001  expected y; bit index = {a,b} (NOR: only idx0 = 1)
//  SETTLE_CYC  2        cycles a/b are held before sampling; legal range >= 1
//  LOOPS       1        full 4-combination sweeps per run; legal range 1..63
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  run request; sampled only in IDLE or DONE
//  y_in       in   1  output of the gate under test
//  a_out      out  1  gate input a (registered)
//  b_out      out  1  gate input b (registered)
//  busy       out  1  high from the cycle after accepted start until DONE
//  done       out  1  level; high in DONE until next accepted start or rst
//  pass       out  1  (err_count == 0) & done
//  err_count  out  8  mismatch count, saturates at 255
//  fail_vec   out  4  sticky; bit i set if combination i ever mismatched this run
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, idx=0, loop=0, cnt=0.
//    All outputs read 0 on the next cycle; reset overrides everything, including mid-run.
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE/DONE, start=1: go to SETTLE.
//    Set idx=0, loop=0, cnt=0, busy=1, done=0; clear err_count and fail_vec.
//  - IDLE/DONE, start=0: hold state; a_out/b_out hold their last values.
//  - start is ignored while busy; there is no queuing.
//  - a_out = idx[1], b_out = idx[0]; both are updated on the same edge that enters SETTLE.
//  - SETTLE: cnt increments each cycle; at cnt == SETTLE_CYC-1 go to SAMPLE and set cnt=0.
//    SETTLE therefore lasts exactly SETTLE_CYC cycles.
//  - SAMPLE: one cycle; y_in is captured at the edge that ends SAMPLE.
//    - y_in != TRUTH[idx]: set fail_vec[idx]; err_count++ unless it is already 255.
//    - idx==3 and loop==LOOPS-1: go to DONE, busy=0, done=1. a_out/b_out stay at 1/1.
//    - idx==3 otherwise: idx wraps to 0, loop++, go to SETTLE.
//    - else: idx++, go to SETTLE.
//  - Latency: start sampled at edge k -> done=1 visible after edge k + 4*LOOPS*(SETTLE_CYC+1).
//  - start=1 in DONE restarts in the same manner as from IDLE (no return to IDLE first).
//  - y_in is ignored outside SAMPLE.
//  - Width rules: idx is 2 bits, wrapping 3->0. loop is 6 bits.
//    cnt is $clog2(SETTLE_CYC+1) bits, minimum 1 bit.
// TESTING
//  1 Correct NOR on y_in, defaults, start pulse at edge 0:
//    a/b = 00,01,10,11, each held 3 cycles; done=1 at edge 12; pass=1, err_count=0, fail_vec=0.
//  2 y_in tied 0, defaults -> err_count=1, fail_vec=4'b0001, pass=0.
//    y_in tied 1 -> err_count=3, fail_vec=4'b1110.
//  3 LOOPS=2, y_in = OR(a,b) (all wrong vs NOR) -> done at edge 24;
//    err_count=8, fail_vec=4'b1111.
//  4 start re-pulsed at edges 3 and 7 of a run -> ignored; done still at edge 12, results unchanged.
//  5 rst=1 during SETTLE of idx=2 -> next cycle IDLE with every output 0.
//    A fresh start then completes a normal sweep.
//  6 start in DONE after a failing run -> err_count/fail_vec cleared, done=0, busy=1 next cycle.
//    With a good gate the run ends with pass=1.

Source files
------------

// File: rtl/gate_truth_sequencer.sv
// Steps a 2-input gate through all four input combinations, samples its
// output after a settle window and scores it against a truth table.
module gate_truth_sequencer #(
  parameter logic [3:0] TRUTH      = 4'b0001,
  parameter int         SETTLE_CYC = 2,
  parameter int         LOOPS      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int CW = ($clog2(SETTLE_CYC + 1) < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [5:0]    LOOP_LAST = 6'(LOOPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d, idx_next;
  logic [5:0]      loop_q, loop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            a_q, a_d, b_q, b_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]      err_q, err_d;
  logic [3:0]      fail_q, fail_d;

  assign idx_next = idx_q + 2'd1;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 2'd0;
          loop_d  = 6'd0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 8'd0;
          fail_d  = 4'b0000;
        end else begin
          state_d = state_q;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (y_in != TRUTH[idx_q]) begin
          fail_d[idx_q] = 1'b1;
          if (err_q != 8'd255) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
        end else begin
          err_d = err_q;
        end
        // Final combination of the last sweep: a/b stay parked at 1/1.
        if ((idx_q == 2'd3) && (loop_q == LOOP_LAST)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
          idx_d   = idx_next;
          a_d     = idx_next[1];
          b_d     = idx_next[0];
          if (idx_q == 2'd3) begin
            loop_d = loop_q + 6'd1;
          end else begin
            loop_d = loop_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pass_d = done_d & (err_d == 8'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      loop_q  <= 6'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer: a default instance driven by a
// switchable gate model and a LOOPS=2 instance driven by an OR gate.
module tb_gate_truth_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] mode = 2'd0;   // 0 NOR, 1 tied 0, 2 tied 1, 3 OR
  logic       y_in, y_in2;
  logic       a_out, b_out, busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;
  logic       a2, b2, busy2, done2, pass2;
  logic [7:0] err2;
  logic [3:0] fail2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd0:    y_in = ~(a_out | b_out);
      2'd1:    y_in = 1'b0;
      2'd2:    y_in = 1'b1;
      default: y_in = a_out | b_out;
    endcase
  end
  assign y_in2 = a2 | b2;

  gate_truth_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_truth_sequencer #(.TRUTH(4'b0001), .SETTLE_CYC(2), .LOOPS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .y_in(y_in2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fail2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start so it is sampled at the next edge (edge 0 of the run).
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  // Full default sweep with per-cycle a/b checks; optionally re-pulse start at edges 3 and 7.
  task automatic sweep(input bit repulse, input string tag);
    do_start();
    check_val({tag, " busy0"}, {31'd0, busy}, 32'd1);
    check_val({tag, " ab0"}, {30'd0, a_out, b_out}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk) start = repulse && (k == 3 || k == 7);
      @(posedge clk) #1;
      if (k < 12) begin
        check_val({tag, " ab"}, {30'd0, a_out, b_out}, k / 3);
        check_val({tag, " done_early"}, {31'd0, done}, 32'd0);
      end else begin
        check_val({tag, " done12"}, {31'd0, done}, 32'd1);
        check_val({tag, " busy12"}, {31'd0, busy}, 32'd0);
        check_val({tag, " ab12"}, {30'd0, a_out, b_out}, 32'd3);
      end
    end
    start = 1'b0;
  endtask

  // Run until done with a cycle bound, then compare the result registers.
  task automatic run_expect(input string tag, input int exp_err, input logic [3:0] exp_fail,
                            input logic exp_pass);
    int n = 0;
    do_start();
    while (!done && n < 200) begin
      @(posedge clk) #1;
      n++;
    end
    check_val({tag, " latency"}, n, 32'd12);
    check_val({tag, " err"}, {24'd0, err_count}, exp_err);
    check_val({tag, " fail_vec"}, {28'd0, fail_vec}, {28'd0, exp_fail});
    check_val({tag, " pass"}, {31'd0, pass}, {31'd0, exp_pass});
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset outs", {a_out, b_out, busy, done, pass, err_count, fail_vec}, 32'd0);
    check_val("reset outs2", {a2, b2, busy2, done2, pass2, err2, fail2}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // 1: good NOR gate
    mode = 2'd0;
    sweep(1'b0, "t1");
    check_val("t1 pass", {31'd0, pass}, 32'd1);
    check_val("t1 err", {24'd0, err_count}, 32'd0);
    check_val("t1 fail_vec", {28'd0, fail_vec}, 32'd0);

    // 2: stuck outputs
    mode = 2'd1;
    run_expect("t2 tie0", 1, 4'b0001, 1'b0);
    mode = 2'd2;
    run_expect("t2 tie1", 3, 4'b1110, 1'b0);

    // 3: LOOPS=2 with an OR gate where NOR is expected
    @(negedge clk) start2 = 1'b1;
    @(posedge clk) #1 start2 = 1'b0;
    n = 0;
    while (!done2 && n < 300) begin
      @(posedge clk) #1;
      n++;
    end
    check_val("t3 latency", n, 32'd24);
    check_val("t3 err", {24'd0, err2}, 32'd8);
    check_val("t3 fail_vec", {28'd0, fail2}, 32'hf);
    check_val("t3 pass", {31'd0, pass2}, 32'd0);

    // 4: start re-pulsed mid-run is ignored
    mode = 2'd0;
    sweep(1'b1, "t4");
    check_val("t4 pass", {31'd0, pass}, 32'd1);
    check_val("t4 err", {24'd0, err_count}, 32'd0);

    // 5: reset during SETTLE of idx=2 (entered at edge 6)
    do_start();
    repeat (6) @(posedge clk);
    #1;
    check_val("t5 ab before rst", {30'd0, a_out, b_out}, 32'd2);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check_val("t5 outs after rst", {a_out, b_out, busy, done, pass, err_count, fail_vec}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("t5 idle hold", {30'd0, busy, done}, 32'd0);
    sweep(1'b0, "t5");
    check_val("t5 pass", {31'd0, pass}, 32'd1);

    // 6: restart from DONE after a failing run
    mode = 2'd1;
    run_expect("t6 bad", 1, 4'b0001, 1'b0);
    mode = 2'd0;
    do_start();
    check_val("t6 cleared err", {24'd0, err_count}, 32'd0);
    check_val("t6 cleared fail", {28'd0, fail_vec}, 32'd0);
    check_val("t6 busy/done", {30'd0, busy, done}, 32'd2);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk) #1;
      n++;
    end
    check_val("t6 latency", n, 32'd12);
    check_val("t6 pass", {31'd0, pass}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
